mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SHALL be: STARVE_LIMIT, 4, max consecutive MEM grants while IF waits (range 1..7).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction
- if_valid  out  1  fetch complete, one-cycle pulse
- mem_req  in  1  data request, held until mem_valid
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_valid  out  1  data access complete, one-cycle pulse
- stall_IF  out  1  fetch pending, freeze IF/ID
- stall_MEM  out  1  data access pending, freeze pipeline
- bus_req  out  1  shared memory request
- bus_we  out  1  shared memory write enable
- bus_addr  out  32  shared memory word address
- bus_wdata  out  32  shared memory write data
- bus_rdata  in  32  shared memory read data
- bus_ack  in  1  shared memory completion, one-cycle pulse
REQ-003 Clock SHALL be the single clock clk; reset SHALL be synchronous and active-high.

Function
REQ-004 FSM SHALL have states IDLE, IF_ACC, MEM_ACC.
REQ-005 In IDLE: if mem_req && (!if_req || starve_cnt < STARVE_LIMIT), go to MEM_ACC; else if if_req, go to IF_ACC; else stay.
REQ-006 On a grant, address, we and wdata of the winner SHALL be latched; bus_addr SHALL be the latched address with [1:0] forced to 0.
REQ-007 bus_req SHALL be 1 exactly in IF_ACC and MEM_ACC; bus_addr, bus_we and bus_wdata SHALL be stable while bus_req is 1.
REQ-008 In IF_ACC, bus_we SHALL be 0; in MEM_ACC, bus_we SHALL equal the latched mem_we.
REQ-009 In an ACC state with bus_ack=1, the FSM SHALL go to IDLE; the matching valid SHALL pulse for exactly one cycle on the next cycle.
REQ-010 For loads and fetches, the matching rdata register SHALL capture bus_rdata with the ack. Stores SHALL leave mem_rdata unchanged.
REQ-011 if_rdata and mem_rdata SHALL hold their values until the next capture.
REQ-012 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle N, bus_req at N+1, ack at N+1, valid at N+2.
REQ-013 At least one IDLE cycle SHALL separate consecutive bus transactions.
REQ-014 starve_cnt (3 bits) SHALL work as follows:
- increment, saturating at STARVE_LIMIT, on each MEM grant while if_req=1;
- clear on each IF grant;
- hold otherwise.
REQ-015 Combinational stall outputs SHALL be stall_IF = if_req & ~if_valid and stall_MEM = mem_req & ~mem_valid.
REQ-016 bus_ack SHALL be ignored in IDLE.
REQ-017 A request dropped mid-transaction SHALL NOT abort the bus access; the valid pulse SHALL still occur.
REQ-018 Simultaneous ack and new requests SHALL complete the current access first; the new requests SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-019 Reset SHALL force state IDLE and starve_cnt=0.
REQ-020 Reset SHALL force bus_req, bus_we, bus_addr, bus_wdata, if_rdata, mem_rdata, if_valid and mem_valid to 0 on the next cycle.
REQ-021 Reset asserted mid-transaction SHALL drop bus_req the next cycle; a later ack SHALL be ignored and produce no valid pulse.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Lone fetch: if_addr=0x00000004, ack one cycle after bus_req, bus_rdata=0x20080005 -> bus_addr=0x4, bus_we=0, if_valid pulse at N+2, if_rdata=0x20080005.
- Contention: if_req and mem_req (load 0x40) in the same cycle -> MEM granted first, IF granted after MEM completes plus one IDLE cycle; stall_IF=1 throughout.
- Starvation: mem_req held high with STARVE_LIMIT=4 and if_req high -> 4 MEM grants, then an IF grant, then starve_cnt=0.
- Store with wait states: mem_we=1, addr=0x4B (unaligned), wdata=0xDEADBEEF, ack after 3 cycles -> bus_addr=0x48, bus_wdata stable 3 cycles, mem_valid pulse, mem_rdata unchanged.
- Reset mid-access: reset while in MEM_ACC, then ack -> bus_req=0 the next cycle, no mem_valid, state IDLE.
- Spurious ack in IDLE -> no valid pulse, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between instruction fetch (IF) and data access (MEM).
// One bus transaction at a time. MEM wins contention unless IF has already
// been passed over STARVE_LIMIT times, in which case IF is granted.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        stall_IF,
    output logic        stall_MEM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

    state_t     state;
    logic [2:0] starve_cnt;
    logic       mem_grant;
    logic       if_grant;

    // Arbitration decision, only acted on in IDLE
    always_comb begin
        mem_grant = mem_req && (!if_req || (starve_cnt < LIMIT));
        if_grant  = !mem_grant && if_req;
    end

    assign stall_IF  = if_req  & ~if_valid;
    assign stall_MEM = mem_req & ~mem_valid;

    // Arbiter FSM; bus fields are latched at grant and held until the next grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            mem_rdata  <= 32'd0;
            if_valid   <= 1'b0;
            mem_valid  <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // bus_ack is ignored here on purpose
                    if (mem_grant) begin
                        state     <= MEM_ACC;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_wdata <= mem_wdata;
                        if (if_req && (starve_cnt < LIMIT))
                            starve_cnt <= starve_cnt + 3'd1;
                    end else if (if_grant) begin
                        state      <= IF_ACC;
                        bus_req    <= 1'b1;
                        bus_we     <= 1'b0;
                        bus_addr   <= {if_addr[31:2], 2'b00};
                        bus_wdata  <= 32'd0;
                        starve_cnt <= 3'd0;
                    end
                end
                IF_ACC: begin
                    // Completes even if if_req was dropped meanwhile
                    if (bus_ack) begin
                        state    <= IDLE;
                        bus_req  <= 1'b0;
                        if_rdata <= bus_rdata;
                        if_valid <= 1'b1;
                    end
                end
                MEM_ACC: begin
                    if (bus_ack) begin
                        state     <= IDLE;
                        bus_req   <= 1'b0;
                        mem_valid <= 1'b1;
                        if (!bus_we)
                            mem_rdata <= bus_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for starvation and reset during an access.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_valid, mem_valid, stall_IF, stall_MEM, bus_req, bus_we;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall_IF(stall_IF), .stall_MEM(stall_MEM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        mr, mw;
        logic [31:0] ma, md, rd;
        logic        ack;
        logic        breq, bwe;
        logic [31:0] baddr, bwd;
        logic        iv, mv;
        logic [31:0] ird, mrd;
        logic        sif, smem;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
    endtask

    initial begin
        //          ir ia         mr mw ma         md            rd            ack  breq bwe baddr       bwd           iv mv ird           mrd           sif smem
        // lone fetch
        tbl[0]  = '{1, 32'h004,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 0, 32'h000, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0};
        tbl[1]  = '{1, 32'h004,   0, 0, 32'h00,    32'h0,        32'h20080005, 1,   1, 0, 32'h004, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0};
        tbl[2]  = '{0, 32'h000,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 0, 32'h004, 32'h0,        1, 0, 32'h20080005, 32'h0,        0, 0};
        // spurious ack in IDLE
        tbl[3]  = '{0, 32'h000,   0, 0, 32'h00,    32'h0,        32'hFFFFFFFF, 1,   0, 0, 32'h004, 32'h0,        0, 0, 32'h20080005, 32'h0,        0, 0};
        tbl[4]  = '{0, 32'h000,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 0, 32'h004, 32'h0,        0, 0, 32'h20080005, 32'h0,        0, 0};
        // contention: MEM load 0x40 first, then IF 0x100
        tbl[5]  = '{1, 32'h100,   1, 0, 32'h40,    32'h0,        32'h0,        0,   0, 0, 32'h004, 32'h0,        0, 0, 32'h20080005, 32'h0,        1, 1};
        tbl[6]  = '{1, 32'h100,   1, 0, 32'h40,    32'h0,        32'hCAFEF00D, 1,   1, 0, 32'h040, 32'h0,        0, 0, 32'h20080005, 32'h0,        1, 1};
        tbl[7]  = '{1, 32'h100,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 0, 32'h040, 32'h0,        0, 1, 32'h20080005, 32'hCAFEF00D, 1, 0};
        tbl[8]  = '{1, 32'h100,   0, 0, 32'h00,    32'h0,        32'h0,        0,   1, 0, 32'h100, 32'h0,        0, 0, 32'h20080005, 32'hCAFEF00D, 1, 0};
        tbl[9]  = '{1, 32'h100,   0, 0, 32'h00,    32'h0,        32'h12345678, 1,   1, 0, 32'h100, 32'h0,        0, 0, 32'h20080005, 32'hCAFEF00D, 1, 0};
        tbl[10] = '{0, 32'h000,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 0, 32'h100, 32'h0,        1, 0, 32'h12345678, 32'hCAFEF00D, 0, 0};
        // unaligned store with wait states
        tbl[11] = '{0, 32'h000,   1, 1, 32'h4B,    32'hDEADBEEF, 32'h0,        0,   0, 0, 32'h100, 32'h0,        0, 0, 32'h12345678, 32'hCAFEF00D, 0, 1};
        tbl[12] = '{0, 32'h000,   1, 1, 32'h4B,    32'hDEADBEEF, 32'h0,        0,   1, 1, 32'h048, 32'hDEADBEEF, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 1};
        tbl[13] = '{0, 32'h000,   1, 1, 32'h4B,    32'hDEADBEEF, 32'h0,        0,   1, 1, 32'h048, 32'hDEADBEEF, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 1};
        tbl[14] = '{0, 32'h000,   1, 1, 32'h4B,    32'hDEADBEEF, 32'hBAD0BAD0, 1,   1, 1, 32'h048, 32'hDEADBEEF, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 1};
        tbl[15] = '{0, 32'h000,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 1, 32'h048, 32'hDEADBEEF, 0, 1, 32'h12345678, 32'hCAFEF00D, 0, 0};
        tbl[16] = '{0, 32'h000,   0, 0, 32'h00,    32'h0,        32'h0,        0,   0, 1, 32'h048, 32'hDEADBEEF, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 0};

        // reset state
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        chk("rst bus_req",   32'(bus_req),   0);
        chk("rst bus_addr",  bus_addr,       0);
        chk("rst if_valid",  32'(if_valid),  0);
        chk("rst mem_valid", 32'(mem_valid), 0);
        chk("rst if_rdata",  if_rdata,       0);
        chk("rst mem_rdata", mem_rdata,      0);
        chk("rst starve",    32'(dut.starve_cnt), 0);
        reset = 0;
        cyc();

        // vector table: drive, settle, compare, advance one clock
        for (int i = 0; i < 17; i++) begin
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            mem_req = tbl[i].mr; mem_we = tbl[i].mw; mem_addr = tbl[i].ma; mem_wdata = tbl[i].md;
            bus_rdata = tbl[i].rd; bus_ack = tbl[i].ack;
            #1;
            chk($sformatf("r%0d bus_req", i),   32'(bus_req),   32'(tbl[i].breq));
            chk($sformatf("r%0d bus_we", i),    32'(bus_we),    32'(tbl[i].bwe));
            chk($sformatf("r%0d bus_addr", i),  bus_addr,       tbl[i].baddr);
            chk($sformatf("r%0d bus_wdata", i), bus_wdata,      tbl[i].bwd);
            chk($sformatf("r%0d if_valid", i),  32'(if_valid),  32'(tbl[i].iv));
            chk($sformatf("r%0d mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
            chk($sformatf("r%0d if_rdata", i),  if_rdata,       tbl[i].ird);
            chk($sformatf("r%0d mem_rdata", i), mem_rdata,      tbl[i].mrd);
            chk($sformatf("r%0d stall_IF", i),  32'(stall_IF),  32'(tbl[i].sif));
            chk($sformatf("r%0d stall_MEM", i), 32'(stall_MEM), 32'(tbl[i].smem));
            cyc();
        end

        // starvation: both held, expect 4 MEM grants then one IF grant
        idle_inputs();
        if_req = 1; if_addr = 32'h200; mem_req = 1; mem_addr = 32'h80;
        for (int g = 0; g < 5; g++) begin
            logic [31:0] exp_addr;
            logic [2:0]  exp_cnt;
            int          n;
            exp_addr = (g < 4) ? 32'h80 : 32'h200;
            exp_cnt  = (g < 4) ? 3'(g + 1) : 3'd0;
            n = 0;
            while (!bus_req && n < 5) begin
                cyc();
                n++;
            end
            chk($sformatf("starve g%0d grant", g), 32'(bus_req), 1);
            chk($sformatf("starve g%0d addr", g), bus_addr, exp_addr);
            chk($sformatf("starve g%0d cnt", g), 32'(dut.starve_cnt), 32'(exp_cnt));
            bus_ack = 1; bus_rdata = 32'h1000 + 32'(g);
            cyc();
            bus_ack = 0;
            chk($sformatf("starve g%0d mem_valid", g), 32'(mem_valid), (g < 4) ? 1 : 0);
            chk($sformatf("starve g%0d if_valid", g),  32'(if_valid),  (g < 4) ? 0 : 1);
            chk($sformatf("starve g%0d stall_MEM", g), 32'(stall_MEM), (g < 4) ? 0 : 1);
        end
        chk("starve if_rdata", if_rdata, 32'h1004);
        idle_inputs();
        cyc();
        chk("starve drained", 32'(bus_req), 0);

        // reset during a MEM access, late ack must be ignored
        mem_req = 1; mem_addr = 32'h10;
        cyc();
        chk("rstacc bus_req", 32'(bus_req), 1);
        reset = 1; mem_req = 0;
        cyc();
        chk("rstacc bus_req drop", 32'(bus_req), 0);
        chk("rstacc bus_addr",     bus_addr, 0);
        chk("rstacc if_rdata",     if_rdata, 0);
        reset = 0; bus_ack = 1; bus_rdata = 32'h55;
        cyc();
        bus_ack = 0;
        chk("rstacc no valid",   32'(mem_valid), 0);
        chk("rstacc no req",     32'(bus_req), 0);
        cyc();
        chk("rstacc no valid2",  32'(mem_valid), 0);
        chk("rstacc mem_rdata",  mem_rdata, 0);
        chk("rstacc state idle", 32'(dut.state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
